// File: rtl/seq_mult_taint.sv
// seq_mult_taint: shift-add sequential multiplier with start/busy/done handshake
// and 1-bit taint tracking on the operands, the start request and the product.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, start_t           request (taken in IDLE or DONE) and its taint
//   multiplier, multiplier_t unsigned operand A and its taint
//   multiplicand, multiplicand_t unsigned operand B and its taint
//   busy                     high while the multiply iterates
//   done                     one-cycle pulse when product is valid
//   done_t                   taint of completion timing (start taint only)
//   product, product_t       A*B and its taint, held until the next completion
module seq_mult_taint #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 start_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 multiplier_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 multiplicand_t,
    output logic                 busy,
    output logic                 done,
    output logic                 done_t,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_t
);

    localparam int unsigned ACC_W  = 2 * WIDTH + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    mr_q, mr_d;
    logic [WIDTH-1:0]    md_q, md_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                op_t_q, op_t_d;
    logic                ctl_t_q, ctl_t_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                done_t_q, done_t_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                product_t_q, product_t_d;

    logic [WIDTH:0]      sum_c;
    logic [ACC_W-1:0]    acc_sum_c;
    logic [ACC_W-1:0]    acc_step_c;
    logic                accept_c;
    logic                last_c;

    // One shift-add iteration: add md into the upper half, then shift right.
    always_comb begin
        sum_c      = acc_q[ACC_W-1:WIDTH] + (mr_q[0] ? {1'b0, md_q} : '0);
        acc_sum_c  = {sum_c, acc_q[WIDTH-1:0]};
        acc_step_c = acc_sum_c >> 1;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mr_d        = mr_q;
        md_d        = md_q;
        count_d     = count_q;
        op_t_d      = op_t_q;
        ctl_t_d     = ctl_t_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        done_t_d    = done_t_q;
        product_d   = product_q;
        product_t_d = product_t_q;

        accept_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_c   = (count_q == CNT_W'(WIDTH - 1));

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_RUN: begin
                acc_d   = acc_step_c;
                mr_d    = mr_q >> 1;
                count_d = count_q + CNT_W'(1);
                busy_d  = 1'b1;
                if (last_c) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    product_d   = acc_step_c[PROD_W-1:0];
                    product_t_d = op_t_q;
                    // Latency is data-independent, so only the start taint
                    // can influence when done fires.
                    done_t_d    = ctl_t_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accepting a request overrides the IDLE/DONE fall-through above.
        if (accept_c) begin
            state_d = S_RUN;
            mr_d    = multiplier;
            md_d    = multiplicand;
            acc_d   = '0;
            count_d = '0;
            op_t_d  = multiplier_t | multiplicand_t | start_t;
            ctl_t_d = start_t;
            busy_d  = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            mr_q        <= '0;
            md_q        <= '0;
            count_q     <= '0;
            op_t_q      <= 1'b0;
            ctl_t_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_t_q    <= 1'b0;
            product_q   <= '0;
            product_t_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mr_q        <= mr_d;
            md_q        <= md_d;
            count_q     <= count_d;
            op_t_q      <= op_t_d;
            ctl_t_q     <= ctl_t_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_t_q    <= done_t_d;
            product_q   <= product_d;
            product_t_q <= product_t_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign done_t    = done_t_q;
    assign product   = product_q;
    assign product_t = product_t_q;

endmodule

// File: doc/seq_mult_taint.md
# seq_mult_taint

Self-contained, parametrised shift-add sequential multiplier with integrated controller and 1-bit-per-signal taint tracking. It replaces the separate controller/datapath pair with a single block that has a start/busy/done handshake, a synchronous reset and WIDTH-generic latency. Operand taint, start taint and control-path taint propagate to the product and handshake outputs. It sits between the operand source and any consumer that must know whether the product or its completion timing depends on tainted data.

## Interface
- WIDTH, 4: operand width in bits; must be ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- start_t  input  1  taint of start.
- multiplier  input  WIDTH  unsigned operand A; sampled when start is accepted.
- multiplier_t  input  1  taint of multiplier.
- multiplicand  input  WIDTH  unsigned operand B; sampled when start is accepted.
- multiplicand_t  input  1  taint of multiplicand.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: product valid.
- done_t  output  1  taint of done/busy timing.
- product  output  2*WIDTH  A*B; held until the next completion.
- product_t  output  1  taint of product.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE with start=1 → RUN.
  - RUN with count==WIDTH-1 → DONE.
  - DONE with start=1 → RUN (back-to-back). DONE with start=0 → IDLE.
- On accept:
  - mr ← multiplier; md ← multiplicand; acc (2*WIDTH+1 bits) ← 0; count ← 0.
  - op_t ← multiplier_t | multiplicand_t | start_t; ctl_t ← start_t.
- Each RUN cycle, in a single step:
  - if mr[0], then acc[2W:W] ← acc[2W:W] + md (W+1-bit sum, no overflow possible).
  - acc is then shifted right logically by 1, and mr is shifted right logically by 1.
  - count increments.
- On entering DONE:
  - product ← acc[2W-1:0] after the final iteration; product_t ← op_t.
  - done_t ← ctl_t.
- Latency is fixed and independent of operand values, so operand taint never reaches done_t. Only start_t does.
- start is ignored while in RUN, and start_t is ignored with it. Operands and taints change only on accept.
- Unsigned only. An operand of 0 still takes the full WIDTH cycles.
- done_t and product_t remain at their last values until the next completion.
- Reset: all outputs are 0 (busy, done, done_t, product, product_t). Internal state: acc, mr, md, count, op_t and ctl_t are 0; state is IDLE.
  - rst overrides start in the same cycle.
  - rst mid-RUN aborts the operation with no done pulse and clears all taint.

## Timing
- start accepted at edge k (state IDLE or DONE).
- busy=1 for cycles k+1 … k+WIDTH.
- done=1 and product/product_t/done_t updated in cycle k+WIDTH+1. busy=0 in that cycle.
- Throughput: one result every WIDTH+1 cycles when start is held high.
- Outputs are registered. There is no combinational path from the inputs to any output.

## Test plan
- WIDTH=4, reset then start with A=13, B=11, no taint → busy for 4 cycles; done pulses at k+5 with product=143 (0x8F), product_t=0, done_t=0.
- WIDTH=4, A=15, B=15, multiplier_t=1 → product=225, product_t=1, done_t=0. Then A=3, B=2 untainted → product=6, product_t=0.
- WIDTH=4, A=0, B=9, start_t=1 → done still at k+5, product=0, product_t=1, done_t=1.
- WIDTH=4, start held high with A=5, B=7, then A=6, B=6 → done at k+5 with product 35, then done at k+10 with product 36. A start pulse during RUN is ignored: operands are unchanged and there is no extra done.
- WIDTH=4, start A=9, B=9, assert rst at k+2 → no done ever. All outputs are 0 from the cycle after rst, and state is IDLE.
- WIDTH=8, A=255, B=255 → done at k+9 with product=65025 (0xFE01). WIDTH=8, A=128, B=2 → product=256.
